// File: rtl/input_buffer.sv
// Weight/input staging buffer between the AHB push stream and the compute array.
// Define IBUF_OCCUPANCY_EN to expose FIFO occupancy as w_level / i_level.
module input_buffer #(
    parameter int DATA_W   = 64,
    parameter int ROWS     = 8,
    parameter int IN_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_push,
    input  logic              is_weight,
    input  logic [DATA_W-1:0] write_data,
    input  logic              start,
    input  logic              clr_err,
    input  logic              array_ready,
    output logic              weight_valid,
    output logic [2:0]        weight_row,
    output logic [DATA_W-1:0] weight_data,
    output logic              input_valid,
    output logic [DATA_W-1:0] input_data,
    output logic              busy,
    output logic              done,
    output logic              err_overrun,
    output logic              err_start
`ifdef IBUF_OCCUPANCY_EN
    ,
    output logic [3:0]                  w_level,
    output logic [$clog2(IN_DEPTH):0]   i_level
`endif
);

    localparam int WAW = $clog2(ROWS);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam logic [WAW:0]   W_FULL   = (WAW+1)'(ROWS);
    localparam logic [IAW:0]   I_FULL   = (IAW+1)'(IN_DEPTH);
    localparam logic [WAW-1:0] W_LAST   = WAW'(ROWS - 1);
    localparam logic [IAW-1:0] I_LAST   = IAW'(IN_DEPTH - 1);
    localparam logic [2:0]     LAST_ROW = 3'(ROWS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0] state, state_d;

    logic [DATA_W-1:0] w_mem [ROWS];
    logic [DATA_W-1:0] i_mem [IN_DEPTH];
    logic [WAW-1:0]    w_wr, w_rd;
    logic [IAW-1:0]    i_wr, i_rd;
    logic [WAW:0]      w_cnt, w_cnt_d;
    logic [IAW:0]      i_cnt, i_cnt_d;
    logic [2:0]        row_cnt;
    logic              start_q;

    logic start_pulse;
    logic w_push, i_push, w_pop, i_pop;
    logic w_full, i_full, w_acc, i_acc;
    logic ovr_set, es_set;

    assign start_pulse = start & ~start_q;
    assign w_push      = wr_en_push & is_weight;
    assign i_push      = wr_en_push & ~is_weight;
    assign w_full      = (w_cnt == W_FULL);
    assign i_full      = (i_cnt == I_FULL);
    assign w_pop       = (state == S_LOAD) & array_ready & (w_cnt != '0);
    assign i_pop       = (state == S_STREAM) & array_ready & (i_cnt != '0);
    // A pop in the same cycle frees the slot the push needs.
    assign w_acc       = w_push & (~w_full | w_pop);
    assign i_acc       = i_push & (~i_full | i_pop);
    assign ovr_set     = (w_push & w_full & ~w_pop) | (i_push & i_full & ~i_pop);
    assign es_set      = (state == S_IDLE) & start_pulse & ~w_full & (w_cnt != '0);

    always_comb begin
        w_cnt_d = w_cnt;
        if (w_acc & ~w_pop)
            w_cnt_d = w_cnt + 1'b1;
        else if (~w_acc & w_pop)
            w_cnt_d = w_cnt - 1'b1;
        i_cnt_d = i_cnt;
        if (i_acc & ~i_pop)
            i_cnt_d = i_cnt + 1'b1;
        else if (~i_acc & i_pop)
            i_cnt_d = i_cnt - 1'b1;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (start_pulse) begin
                    if (w_full)
                        state_d = S_LOAD;
                    else if (w_cnt == '0)
                        state_d = S_STREAM;
                end
            end
            S_LOAD: begin
                if (w_pop && row_cnt == LAST_ROW)
                    state_d = S_STREAM;
            end
            S_STREAM: begin
                if (i_cnt == '0 && !i_push)
                    state_d = S_FINISH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_acc)
            w_mem[w_wr] <= write_data;
        if (i_acc)
            i_mem[i_wr] <= write_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            start_q      <= 1'b0;
            w_wr         <= '0;
            w_rd         <= '0;
            i_wr         <= '0;
            i_rd         <= '0;
            w_cnt        <= '0;
            i_cnt        <= '0;
            row_cnt      <= '0;
            weight_valid <= 1'b0;
            weight_row   <= '0;
            weight_data  <= '0;
            input_valid  <= 1'b0;
            input_data   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_overrun  <= 1'b0;
            err_start    <= 1'b0;
        end else begin
            state   <= state_d;
            start_q <= start;
            w_cnt   <= w_cnt_d;
            i_cnt   <= i_cnt_d;
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_FINISH);

            if (w_acc)
                w_wr <= (w_wr == W_LAST) ? '0 : w_wr + 1'b1;
            if (i_acc)
                i_wr <= (i_wr == I_LAST) ? '0 : i_wr + 1'b1;

            weight_valid <= w_pop;
            if (w_pop) begin
                weight_data <= w_mem[w_rd];
                weight_row  <= row_cnt;
                row_cnt     <= row_cnt + 1'b1;
                w_rd        <= (w_rd == W_LAST) ? '0 : w_rd + 1'b1;
            end else if (state == S_IDLE && state_d == S_LOAD) begin
                row_cnt <= '0;
            end

            input_valid <= i_pop;
            if (i_pop) begin
                input_data <= i_mem[i_rd];
                i_rd       <= (i_rd == I_LAST) ? '0 : i_rd + 1'b1;
            end

            // Set beats clear when both land in the same cycle.
            if (ovr_set)
                err_overrun <= 1'b1;
            else if (clr_err)
                err_overrun <= 1'b0;
            if (es_set)
                err_start <= 1'b1;
            else if (clr_err)
                err_start <= 1'b0;
        end
    end

`ifdef IBUF_OCCUPANCY_EN
    assign w_level = 4'(w_cnt);
    assign i_level = i_cnt;
`endif

endmodule

// File: tb/tb_input_buffer.sv
// Directed and random checks of input_buffer against a queue-based reference.
module tb_input_buffer;

    localparam int ROWS     = 8;
    localparam int IN_DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        wr_en_push;
    logic        is_weight;
    logic [63:0] write_data;
    logic        start;
    logic        clr_err;
    logic        array_ready;
    logic        weight_valid;
    logic [2:0]  weight_row;
    logic [63:0] weight_data;
    logic        input_valid;
    logic [63:0] input_data;
    logic        busy;
    logic        done;
    logic        err_overrun;
    logic        err_start;

    input_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en_push   (wr_en_push),
        .is_weight    (is_weight),
        .write_data   (write_data),
        .start        (start),
        .clr_err      (clr_err),
        .array_ready  (array_ready),
        .weight_valid (weight_valid),
        .weight_row   (weight_row),
        .weight_data  (weight_data),
        .input_valid  (input_valid),
        .input_data   (input_data),
        .busy         (busy),
        .done         (done),
        .err_overrun  (err_overrun),
        .err_start    (err_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef enum int {M_IDLE, M_LOAD, M_STREAM, M_FIN} mode_t;
    logic [63:0] wq[$];
    logic [63:0] iq[$];
    mode_t       mode;
    int          rows_done;
    bit          prev_start;

    logic        e_wv, e_iv, e_busy, e_done, e_eo, e_es;
    logic [2:0]  e_wrow;
    logic [63:0] e_wd, e_id;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: one clock of the documented behaviour at queue level.
    task automatic model_cycle();
        bit pulse, wpush, ipush, wpop, ipop, so, ss;
        int wsz, isz;
        if (rst) begin
            wq.delete();
            iq.delete();
            mode = M_IDLE;
            prev_start = 0;
            rows_done = 0;
            {e_wv, e_iv, e_busy, e_done, e_eo, e_es} = '0;
            e_wrow = '0;
            e_wd = '0;
            e_id = '0;
            return;
        end
        pulse = start && !prev_start;
        prev_start = start;
        wpush = wr_en_push && is_weight;
        ipush = wr_en_push && !is_weight;
        wsz = wq.size();
        isz = iq.size();
        wpop = (mode == M_LOAD) && array_ready && wsz > 0;
        ipop = (mode == M_STREAM) && array_ready && isz > 0;
        e_wv = wpop;
        if (wpop) begin
            e_wd = wq.pop_front();
            e_wrow = 3'(rows_done);
        end
        e_iv = ipop;
        if (ipop)
            e_id = iq.pop_front();
        so = 0;
        ss = 0;
        if (wpush) begin
            if (wq.size() < ROWS) wq.push_back(write_data);
            else so = 1;
        end
        if (ipush) begin
            if (iq.size() < IN_DEPTH) iq.push_back(write_data);
            else so = 1;
        end
        case (mode)
            M_IDLE:
                if (pulse) begin
                    if (wsz == ROWS) begin
                        mode = M_LOAD;
                        rows_done = 0;
                    end else if (wsz == 0) mode = M_STREAM;
                    else ss = 1;
                end
            M_LOAD:
                if (wpop) begin
                    rows_done++;
                    if (rows_done == ROWS) mode = M_STREAM;
                end
            M_STREAM:
                if (isz == 0 && !ipush) mode = M_FIN;
            default: mode = M_IDLE;
        endcase
        e_busy = (mode != M_IDLE);
        e_done = (mode == M_FIN);
        e_eo = so ? 1'b1 : (clr_err ? 1'b0 : e_eo);
        e_es = ss ? 1'b1 : (clr_err ? 1'b0 : e_es);
    endtask

    task automatic step(input bit p, input bit w, input logic [63:0] d,
                        input bit s, input bit c, input bit r, input bit rs);
        wr_en_push = p;
        is_weight = w;
        write_data = d;
        start = s;
        clr_err = c;
        array_ready = r;
        rst = rs;
        model_cycle();
        @(posedge clk);
        #1;
        chk("weight_valid", 64'(weight_valid), 64'(e_wv));
        chk("weight_row", 64'(weight_row), 64'(e_wrow));
        chk("weight_data", weight_data, e_wd);
        chk("input_valid", 64'(input_valid), 64'(e_iv));
        chk("input_data", input_data, e_id);
        chk("busy", 64'(busy), 64'(e_busy));
        chk("done", 64'(done), 64'(e_done));
        chk("err_overrun", 64'(err_overrun), 64'(e_eo));
        chk("err_start", 64'(err_start), 64'(e_es));
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [63:0] sent[$];
        logic [63:0] got[$];
        logic [7:0]  b;
        int done_n, done_at, busy_fall, pops;
        bit busy_prev;

        {wr_en_push, is_weight, start, clr_err, array_ready} = '0;
        write_data = '0;
        rst = 1'b1;
        e_eo = 0;
        e_es = 0;

        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_wv", 64'(weight_valid), 64'(0));
        step(0, 0, 0, 0, 0, 0, 0);

        // full weight load
        for (int k = 1; k <= 8; k++) begin
            b = 8'(k * 17);
            step(1, 1, {8{b}}, 0, 0, 0, 0);
        end
        step(0, 0, 0, 1, 0, 1, 0);
        chk("t1_busy", 64'(busy), 64'(1));
        for (int r = 0; r < 8; r++) begin
            b = 8'((r + 1) * 17);
            step(0, 0, 0, 1, 0, 1, 0);
            chk("t1_wv", 64'(weight_valid), 64'(1));
            chk("t1_row", 64'(weight_row), 64'(r));
            chk("t1_data", weight_data, {8{b}});
        end
        step(0, 0, 0, 1, 0, 1, 0);
        chk("t1_done", 64'(done), 64'(1));
        step(0, 0, 0, 1, 0, 1, 0);
        chk("t1_done_end", 64'(done), 64'(0));
        chk("t1_idle", 64'(busy), 64'(0));
        step(0, 0, 0, 0, 0, 0, 0);

        // weights + 3 inputs, ready toggling
        for (int k = 0; k < 8; k++) step(1, 1, rnd64(), 0, 0, 0, 0);
        step(1, 0, 64'hA, 0, 0, 0, 0);
        step(1, 0, 64'hB, 0, 0, 0, 0);
        step(1, 0, 64'hC, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 0);
        done_n = 0;
        done_at = -1;
        busy_fall = -1;
        busy_prev = busy;
        got.delete();
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 0, 0, (i % 2) == 0, 0);
            if (input_valid) got.push_back(input_data);
            if (done) begin
                done_n++;
                done_at = i;
            end
            if (busy_prev && !busy) busy_fall = i;
            busy_prev = busy;
        end
        chk("t2_npop", 64'(got.size()), 64'(3));
        if (got.size() == 3) begin
            chk("t2_in0", got[0], 64'hA);
            chk("t2_in1", got[1], 64'hB);
            chk("t2_in2", got[2], 64'hC);
        end
        chk("t2_done_n", 64'(done_n), 64'(1));
        chk("t2_busy_fall", 64'(busy_fall), 64'(done_at + 1));

        // input overrun
        sent.delete();
        for (int k = 0; k < 9; k++) begin
            sent.push_back(rnd64());
            step(1, 0, sent[k], 0, 0, 0, 0);
        end
        chk("t3_ovr", 64'(err_overrun), 64'(1));
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0);
        chk("t3_ovr_sticky", 64'(err_overrun), 64'(1));
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t3_ovr_clr", 64'(err_overrun), 64'(0));
        step(0, 0, 0, 1, 0, 1, 0);
        got.delete();
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0, 1, 0);
            if (input_valid) got.push_back(input_data);
        end
        chk("t3_drain", 64'(got.size()), 64'(8));
        if (got.size() == 8) chk("t3_last", got[7], sent[7]);

        // partial weight set
        for (int k = 0; k < 5; k++) step(1, 1, rnd64(), 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 0);
        chk("t4_es", 64'(err_start), 64'(1));
        chk("t4_busy", 64'(busy), 64'(0));
        step(0, 0, 0, 1, 0, 1, 0);
        chk("t4_wv", 64'(weight_valid), 64'(0));
        chk("t4_iv", 64'(input_valid), 64'(0));
        for (int k = 0; k < 3; k++) step(1, 1, rnd64(), 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t4_es_clr", 64'(err_start), 64'(0));
        step(0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 1, 0);

        // full input FIFO, push and pop together
        for (int k = 0; k < 8; k++) step(1, 0, rnd64(), 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, rnd64(), 0, 0, 1, 0);
        chk("t5_ovr", 64'(err_overrun), 64'(0));
        chk("t5_iv", 64'(input_valid), 64'(1));
        pops = 1;
        for (int i = 0; i < 14; i++) begin
            step(0, 0, 0, 0, 0, 1, 0);
            if (input_valid) pops++;
        end
        chk("t5_pops", 64'(pops), 64'(9));

        // reset during weight load
        for (int k = 0; k < 8; k++) step(1, 1, rnd64(), 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 1, 0);
        chk("t6_row", 64'(weight_row), 64'(2));
        step(0, 0, 0, 0, 0, 1, 1);
        chk("t6_wv", 64'(weight_valid), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        done_n = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 1, 0);
            if (done) done_n++;
        end
        chk("t6_nodone", 64'(done_n), 64'(0));
        step(0, 0, 0, 1, 0, 1, 0);
        chk("t6_es", 64'(err_start), 64'(0));
        chk("t6_busy2", 64'(busy), 64'(1));
        step(0, 0, 0, 1, 0, 1, 0);
        chk("t6_done", 64'(done), 64'(1));
        step(0, 0, 0, 0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 45, $urandom_range(0, 1) == 1, rnd64(),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
